control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives the data_path control inputs for the instruction subset ld, ldi, st, addi, br, nop and halt.
- Generates the fetch sequence (T0-T2) and per-opcode execute sequences (T3-T7) each clock.
- Replaces hand-driven control and sits beside data_path, sharing Clock; it consumes irOut and branchCompare.

Parameters:
- OPW, 5, width of the opcode field ir[31:27] and of the op output.
- ALU_ADD, 5'b00011, ALU op code driven on op for every address or sum computation.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous active-low reset.
- ir  in  32  instruction register contents; opcode is ir[31:27].
- con_ff  in  1  branch condition (branchCompare) from data_path.
- stop  in  1  request to halt at the next instruction boundary.
- PCout, Zlowout, MDRout, Cout  out  1 each  bus drive selects.
- MARin, PCin, MDRin, IRin, Yin, Zhighin, Zlowin, IncPC  out  1 each  register loads.
- Read, Write  out  1 each  memory strobes.
- Gra, Grb, Rin, Rout, BAOut, CONin  out  1 each  select/encode and CON FF load.
- op  out  OPW  ALU operation; 5'b00000 when idle.
- run  out  1  high while executing; low in RST and HALT.
- state_out  out  5  current state encoding, for debug.

Behaviour:
- Reset:
  - clear=0 forces state RST asynchronously.
  - In RST, all outputs are 0 (op=0, run=0).
  - On the first rising edge after clear=1, the state goes to T0.
- Moore outputs are a pure function of the state register. Each state lasts exactly 1 cycle. Any signal not listed for a state is 0.
- Fetch (all opcodes):
  - T0: PCout MARin IncPC Zhighin Zlowin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
  - The next state is picked from ir[31:27] sampled at the T2->T3 edge. IR is loaded during T2, so decode uses the value present at the end of T2.
- Opcodes: ld=00000, ldi=00001, st=00010, addi=01100, br=10010, nop=11010, halt=11011.
- ldi:
  - T3: Grb BAOut Yin.
  - T4: Cout op=ALU_ADD Zhighin Zlowin.
  - T5: Zlowout Gra Rin, then T0.
  - 6 cycles total.
- ld:
  - T3 and T4 as ldi.
  - T5: Zlowout MARin.
  - T6: Read MDRin.
  - T7: MDRout Gra Rin, then T0.
  - 8 cycles.
- st:
  - T3 and T4 as ldi.
  - T5: Zlowout MARin.
  - T6: Gra Rout MDRin, with Read=0 so MDR loads from the bus.
  - T7: Write, then T0.
- addi:
  - T3: Grb Rout Yin.
  - T4: Cout op=ALU_ADD Zhighin Zlowin.
  - T5: Zlowout Gra Rin, then T0.
- br:
  - T3: Gra Rout CONin.
  - T4: PCout Yin.
  - T5: Cout op=ALU_ADD Zhighin Zlowin.
  - T6: Zlowout, plus PCin only if con_ff=1 during T6, then T0.
  - Not-taken still spends T6, with Zlowout only.
- nop: T2 goes directly to T0; 3 cycles total.
- halt: T2 goes to HALT. In HALT, outputs are 0 and run=0. HALT is left only via clear.
- stop:
  - stop is sampled on every edge whose next state would be T0; if stop=1, the next state is HALT instead.
  - stop is ignored in the middle of an instruction; the current instruction always completes.
- Unknown opcode: behaviour depends on SEQ_ILLEGAL_TRAP_EN (see Optional Feature).
- Mutual exclusion: at most one bus driver (PCout, Zlowout, MDRout, Cout, Rout, BAOut) is high in any state. Write and Read are never both high.
- Reset mid-instruction: returns to RST immediately. Any partially completed register write is abandoned, with no further strobes.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal (1 bit, reset 0).
  - An unknown opcode at T2 goes to HALT and sets illegal=1. illegal stays set until clear.
- Undefined: an unknown opcode behaves exactly as nop, and the illegal port does not exist.

Test Plan:
- Reset: hold clear=0 for 3 cycles with stop=0 -> all outputs 0, state_out=RST. Release -> next cycle T0 with PCout=MARin=IncPC=Zhighin=Zlowin=1, run=1.
- ldi: ir=32'h0880_0005 (ldi, Ra=R1, Rb=R0, C=5) -> exact sequence T0,T1,T2,T3(Grb BAOut Yin),T4(Cout op=00011),T5(Gra Rin Zlowout) -> T0; 6 cycles.
- st vs ld: st ir=32'h1080_0010 -> Write=1 only in T7, Read=0 throughout T3-T7. ld ir=32'h0080_0010 -> Read=MDRin=1 in T6 and Gra=Rin=1 in T7; 8 cycles each.
- br: ir=32'h9000_0004 with con_ff=1 -> PCin=1 in T6. Repeat with con_ff=0 -> PCin=0 in T6 and Zlowout=1. Both take 7 cycles.
- stop/halt:
  - Assert stop=1 during T4 of addi -> T5 completes (Rin=1), then HALT with run=0.
  - halt opcode 5'b11011 -> HALT after T2; stays there 10 cycles until clear.
- Illegal/reset: opcode 5'b11111 with macro -> HALT, illegal=1; without macro -> T0 after T2. Pulse clear=0 during ld T6 -> immediate RST, Read=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer driving the data_path control inputs for ld/ldi/st/addi/br/nop/halt.
// Optional macro SEQ_ILLEGAL_TRAP_EN: unknown opcodes halt and raise the illegal output.
module control_sequencer #(
  parameter int unsigned    OPW     = 5,
  parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  input  logic           stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Cout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zhighin,
  output logic           Zlowin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           Gra,
  output logic           Grb,
  output logic           Rin,
  output logic           Rout,
  output logic           BAOut,
  output logic           CONin,
  output logic [OPW-1:0] op,
`ifdef SEQ_ILLEGAL_TRAP_EN
  output logic           illegal,
`endif
  output logic           run,
  output logic [4:0]     state_out
);

  typedef enum logic [4:0] {
    StRst  = 5'd0,
    StT0   = 5'd1,
    StT1   = 5'd2,
    StT2   = 5'd3,
    StT3   = 5'd4,
    StT4   = 5'd5,
    StT5   = 5'd6,
    StT6   = 5'd7,
    StT7   = 5'd8,
    StHalt = 5'd9
  } state_e;

  typedef enum logic [2:0] {ClsLd, ClsLdi, ClsSt, ClsAddi, ClsBr} cls_e;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpBr   = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  state_e     boundary_st;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`endif

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q   <= StRst;
      cls_q     <= ClsLd;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    // stop only takes effect at an instruction boundary
    boundary_st = stop ? StHalt : StT0;
    unique case (state_q)
      StRst: state_d = StT0;
      StT0:  state_d = StT1;
      StT1:  state_d = StT2;
      StT2: begin
        state_d = StT3;
        case (opcode)
          OpLd:   cls_d = ClsLd;
          OpLdi:  cls_d = ClsLdi;
          OpSt:   cls_d = ClsSt;
          OpAddi: cls_d = ClsAddi;
          OpBr:   cls_d = ClsBr;
          OpNop:  state_d = boundary_st;
          OpHalt: state_d = StHalt;
          default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_d   = StHalt;
            illegal_d = 1'b1;
`else
            state_d   = boundary_st;
`endif
          end
        endcase
      end
      StT3: state_d = StT4;
      StT4: state_d = StT5;
      StT5: state_d = (cls_q == ClsLdi || cls_q == ClsAddi) ? boundary_st : StT6;
      StT6: state_d = (cls_q == ClsBr) ? boundary_st : StT7;
      StT7: state_d = boundary_st;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zhighin} = '0;
    {Zlowin, IncPC, Read, Write, Gra, Grb, Rin, Rout, BAOut, CONin}        = '0;
    op = '0;
    unique case (state_q)
      StT0: {PCout, MARin, IncPC, Zhighin, Zlowin} = '1;
      StT1: {Zlowout, PCin, Read, MDRin} = '1;
      StT2: {MDRout, IRin} = '1;
      StT3: begin
        case (cls_q)
          ClsAddi: {Grb, Rout, Yin} = '1;
          ClsBr:   {Gra, Rout, CONin} = '1;
          default: {Grb, BAOut, Yin} = '1;
        endcase
      end
      StT4: begin
        if (cls_q == ClsBr) begin
          {PCout, Yin} = '1;
        end else begin
          {Cout, Zhighin, Zlowin} = '1;
          op = ALU_ADD;
        end
      end
      StT5: begin
        case (cls_q)
          ClsBr: begin
            {Cout, Zhighin, Zlowin} = '1;
            op = ALU_ADD;
          end
          ClsLd, ClsSt: {Zlowout, MARin} = '1;
          default:      {Zlowout, Gra, Rin} = '1;
        endcase
      end
      StT6: begin
        case (cls_q)
          ClsBr: begin
            Zlowout = 1'b1;
            PCin    = con_ff;
          end
          ClsSt:   {Gra, Rout, MDRin} = '1;
          default: {Read, MDRin} = '1;
        endcase
      end
      StT7: begin
        if (cls_q == ClsSt) Write = 1'b1;
        else                {MDRout, Gra, Rin} = '1;
      end
      default: ;
    endcase
  end

  assign run       = (state_q != StRst) && (state_q != StHalt);
  assign state_out = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: per-cycle control vectors for each opcode,
// stop/halt handling, illegal opcodes and asynchronous reset.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear, con_ff, stop;
  logic [31:0] ir;
  logic PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zhighin;
  logic Zlowin, IncPC, Read, Write, Gra, Grb, Rin, Rout, BAOut, CONin;
  logic [4:0]  op;
  logic        run;
  logic [4:0]  state_out;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [19:0] PCO = 20'h80000, ZLO = 20'h40000, MDRO = 20'h20000, CO = 20'h10000;
  localparam logic [19:0] MARI = 20'h08000, PCI = 20'h04000, MDRI = 20'h02000, IRI = 20'h01000;
  localparam logic [19:0] YI = 20'h00800, ZHI = 20'h00400, ZLI = 20'h00200, INC = 20'h00100;
  localparam logic [19:0] RD = 20'h00080, WR = 20'h00040, GRA = 20'h00020, GRB = 20'h00010;
  localparam logic [19:0] RIN = 20'h00008, ROUT = 20'h00004, BAO = 20'h00002, CONI = 20'h00001;
  localparam logic [19:0] F_T0 = PCO | MARI | INC | ZHI | ZLI;
  localparam logic [19:0] F_T1 = ZLO | PCI | RD | MDRI;
  localparam logic [19:0] F_T2 = MDRO | IRI;
  localparam logic [4:0]  ADD = 5'b00011;
  localparam logic [4:0]  S_RST = 5'd0, S_T0 = 5'd1, S_T1 = 5'd2, S_T2 = 5'd3, S_T3 = 5'd4;
  localparam logic [4:0]  S_T4 = 5'd5, S_T5 = 5'd6, S_T6 = 5'd7, S_T7 = 5'd8, S_HALT = 5'd9;

  logic [19:0] ctl;
  assign ctl = {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zhighin,
                Zlowin, IncPC, Read, Write, Gra, Grb, Rin, Rout, BAOut, CONin};

  control_sequencer dut (
    .Clock    (Clock),
    .clear    (clear),
    .ir       (ir),
    .con_ff   (con_ff),
    .stop     (stop),
    .PCout    (PCout),
    .Zlowout  (Zlowout),
    .MDRout   (MDRout),
    .Cout     (Cout),
    .MARin    (MARin),
    .PCin     (PCin),
    .MDRin    (MDRin),
    .IRin     (IRin),
    .Yin      (Yin),
    .Zhighin  (Zhighin),
    .Zlowin   (Zlowin),
    .IncPC    (IncPC),
    .Read     (Read),
    .Write    (Write),
    .Gra      (Gra),
    .Grb      (Grb),
    .Rin      (Rin),
    .Rout     (Rout),
    .BAOut    (BAOut),
    .CONin    (CONin),
    .op       (op),
`ifdef SEQ_ILLEGAL_TRAP_EN
    .illegal  (illegal),
`endif
    .run      (run),
    .state_out(state_out)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Returns to T0 via a clear pulse (used after HALT).
  task automatic recover();
    clear = 1'b0;
    #1;
    clear = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = '0;
    repeat (3) @(posedge Clock);
    #1;
    tests++;
    if ({state_out, op, run, ctl} !== {S_RST, 5'd0, 1'b0, 20'd0}) begin
      fails++;
      $display("FAIL reset_hold: state=%0d op=%b run=%b ctl=%h, want state=0 op=0 run=0 ctl=0",
               state_out, op, run, ctl);
    end
    clear = 1'b1;
    step();
    tests++;
    if ({state_out, op, run, ctl} !== {S_T0, 5'd0, 1'b1, F_T0}) begin
      fails++;
      $display("FAIL reset_release: state=%0d op=%b run=%b ctl=%h, want state=%0d run=1 ctl=%h",
               state_out, op, run, ctl, S_T0, F_T0);
    end
  endtask

  task automatic test_ldi();
    logic [19:0] ec [6];
    logic [4:0]  es [6];
    logic [4:0]  eo [6];
    ec = '{F_T0, F_T1, F_T2, GRB | BAO | YI, CO | ZHI | ZLI, ZLO | GRA | RIN};
    es = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, ADD, 5'd0};
    ir = 32'h0880_0005;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if ({state_out, op, run, ctl} !== {es[i], eo[i], 1'b1, ec[i]}) begin
        fails++;
        $display("FAIL ldi_c%0d: state=%0d op=%b run=%b ctl=%h, want state=%0d op=%b ctl=%h",
                 i, state_out, op, run, ctl, es[i], eo[i], ec[i]);
      end
      step();
    end
    tests++;
    if (state_out !== S_T0) begin
      fails++;
      $display("FAIL ldi_end: state=%0d, want %0d", state_out, S_T0);
    end
  endtask

  task automatic test_load_store();
    logic [19:0] ec [8];
    logic [4:0]  es [8];
    logic [4:0]  eo [8];
    es = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, ADD, 5'd0, 5'd0, 5'd0};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ir = 32'h1080_0010;
        ec = '{F_T0, F_T1, F_T2, GRB | BAO | YI, CO | ZHI | ZLI, ZLO | MARI,
               GRA | ROUT | MDRI, WR};
      end else begin
        ir = 32'h0080_0010;
        ec = '{F_T0, F_T1, F_T2, GRB | BAO | YI, CO | ZHI | ZLI, ZLO | MARI,
               RD | MDRI, MDRO | GRA | RIN};
      end
      for (int i = 0; i < 8; i++) begin
        tests++;
        if ({state_out, op, run, ctl} !== {es[i], eo[i], 1'b1, ec[i]}) begin
          fails++;
          $display("FAIL %s_c%0d: state=%0d op=%b run=%b ctl=%h, want state=%0d op=%b ctl=%h",
                   (k == 0) ? "st" : "ld", i, state_out, op, run, ctl, es[i], eo[i], ec[i]);
        end
        step();
      end
      tests++;
      if (state_out !== S_T0) begin
        fails++;
        $display("FAIL ldst_end%0d: state=%0d, want %0d", k, state_out, S_T0);
      end
    end
  endtask

  task automatic test_branch();
    logic [19:0] ec [7];
    logic [4:0]  es [7];
    logic [4:0]  eo [7];
    es = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, ADD, 5'd0};
    ir = 32'h9000_0004;
    for (int k = 0; k < 2; k++) begin
      con_ff = (k == 0);
      ec = '{F_T0, F_T1, F_T2, GRA | ROUT | CONI, PCO | YI, CO | ZHI | ZLI,
             (k == 0) ? (ZLO | PCI) : ZLO};
      for (int i = 0; i < 7; i++) begin
        tests++;
        if ({state_out, op, run, ctl} !== {es[i], eo[i], 1'b1, ec[i]}) begin
          fails++;
          $display("FAIL br%0d_c%0d: state=%0d op=%b run=%b ctl=%h, want state=%0d op=%b ctl=%h",
                   k, i, state_out, op, run, ctl, es[i], eo[i], ec[i]);
        end
        step();
      end
      tests++;
      if (state_out !== S_T0) begin
        fails++;
        $display("FAIL br_end%0d: state=%0d, want %0d", k, state_out, S_T0);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_nop_stop();
    ir = 32'hD000_0000;
    repeat (3) step();
    tests++;
    if ({state_out, ctl} !== {S_T0, F_T0}) begin
      fails++;
      $display("FAIL nop_len: state=%0d ctl=%h, want state=%0d ctl=%h", state_out, ctl, S_T0, F_T0);
    end
    // stop raised in T2 of a nop lands in HALT at the boundary
    repeat (2) step();
    stop = 1'b1;
    step();
    tests++;
    if ({state_out, op, run, ctl} !== {S_HALT, 5'd0, 1'b0, 20'd0}) begin
      fails++;
      $display("FAIL nop_stop: state=%0d op=%b run=%b ctl=%h, want state=%0d run=0 ctl=0",
               state_out, op, run, ctl, S_HALT);
    end
    stop = 1'b0;
    recover();
  endtask

  task automatic test_stop_addi();
    ir = 32'h6080_0003;
    step();
    step();
    tests++;
    if ({state_out, ctl} !== {S_T2, F_T2}) begin
      fails++;
      $display("FAIL addi_t2: state=%0d ctl=%h, want state=%0d ctl=%h", state_out, ctl, S_T2, F_T2);
    end
    step();
    tests++;
    if (ctl !== (GRB | ROUT | YI)) begin
      fails++;
      $display("FAIL addi_t3: ctl=%h, want %h", ctl, GRB | ROUT | YI);
    end
    step();
    stop = 1'b1;
    step();
    tests++;
    if ({state_out, run, ctl} !== {S_T5, 1'b1, ZLO | GRA | RIN}) begin
      fails++;
      $display("FAIL addi_stop_t5: state=%0d run=%b ctl=%h, want state=%0d run=1 ctl=%h",
               state_out, run, ctl, S_T5, ZLO | GRA | RIN);
    end
    step();
    tests++;
    if ({state_out, run, ctl} !== {S_HALT, 1'b0, 20'd0}) begin
      fails++;
      $display("FAIL addi_stop_halt: state=%0d run=%b ctl=%h, want state=%0d run=0 ctl=0",
               state_out, run, ctl, S_HALT);
    end
    stop = 1'b0;
    recover();
  endtask

  task automatic test_halt();
    ir = 32'hD800_0000;
    repeat (3) step();
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({state_out, op, run, ctl} !== {S_HALT, 5'd0, 1'b0, 20'd0}) begin
        fails++;
        $display("FAIL halt_c%0d: state=%0d op=%b run=%b ctl=%h, want state=%0d run=0 ctl=0",
                 i, state_out, op, run, ctl, S_HALT);
      end
      step();
    end
    clear = 1'b0;
    #1;
    tests++;
    if ({state_out, run} !== {S_RST, 1'b0}) begin
      fails++;
      $display("FAIL halt_clear: state=%0d run=%b, want state=0 run=0", state_out, run);
    end
    clear = 1'b1;
    step();
    tests++;
    if ({state_out, run, ctl} !== {S_T0, 1'b1, F_T0}) begin
      fails++;
      $display("FAIL halt_restart: state=%0d run=%b ctl=%h, want state=%0d", state_out, run, ctl, S_T0);
    end
  endtask

  task automatic test_illegal();
    ir = 32'hF800_0000;
    repeat (3) step();
`ifdef SEQ_ILLEGAL_TRAP_EN
    repeat (2) step();
    tests++;
    if ({state_out, run, illegal} !== {S_HALT, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL illegal_trap: state=%0d run=%b illegal=%b, want state=%0d run=0 illegal=1",
               state_out, run, illegal, S_HALT);
    end
    recover();
    tests++;
    if (illegal !== 1'b0) begin
      fails++;
      $display("FAIL illegal_clear: illegal=%b, want 0", illegal);
    end
`else
    tests++;
    if ({state_out, run, ctl} !== {S_T0, 1'b1, F_T0}) begin
      fails++;
      $display("FAIL illegal_as_nop: state=%0d run=%b ctl=%h, want state=%0d ctl=%h",
               state_out, run, ctl, S_T0, F_T0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    ir = 32'h0080_0010;
    repeat (6) step();
    tests++;
    if ({state_out, ctl} !== {S_T6, RD | MDRI}) begin
      fails++;
      $display("FAIL ld_t6: state=%0d ctl=%h, want state=%0d ctl=%h", state_out, ctl, S_T6, RD | MDRI);
    end
    #2;
    clear = 1'b0;
    #1;
    tests++;
    if ({state_out, Read, run, ctl} !== {S_RST, 1'b0, 1'b0, 20'd0}) begin
      fails++;
      $display("FAIL reset_mid: state=%0d Read=%b run=%b ctl=%h, want state=0 Read=0 run=0 ctl=0",
               state_out, Read, run, ctl);
    end
    step();
    tests++;
    if ({state_out, ctl} !== {S_RST, 20'd0}) begin
      fails++;
      $display("FAIL reset_mid_hold: state=%0d ctl=%h, want state=0 ctl=0", state_out, ctl);
    end
    clear = 1'b1;
    step();
    tests++;
    if ({state_out, run} !== {S_T0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_restart: state=%0d run=%b, want state=%0d run=1",
               state_out, run, S_T0);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_load_store();
    test_branch();
    test_nop_stop();
    test_stop_addi();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
